// File: rtl/tt_um_calonso88_rsa_core.sv
// tt_um_calonso88_rsa_core: constant-time 8-bit modular exponentiation C = M^E mod N
module tt_um_calonso88_rsa_core (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] INIT = 3'd1;
  localparam logic [2:0] MUL  = 3'd2;
  localparam logic [2:0] SQR  = 3'd3;
  localparam logic [2:0] FIN  = 3'd4;
  logic [2:0] state_q, state_d, cnt_q, bit_q;
  logic [7:0] m_q, e_q, n_q, res_q, r_q, s_q, a_op;
  logic [9:0] p_q, p_add, p_sub, p_mod;
  logic start_q, arm_q, busy_q, done_q, err_q;
  logic start_rise, op_bad, last, unused_w;
  assign start_rise = ui_in[3] & ~start_q & arm_q & ~busy_q;
  assign op_bad     = (n_q < 8'd2) | (m_q >= n_q);
  assign last       = cnt_q == 3'd7;
  assign a_op       = state_q == MUL ? r_q : s_q;
  assign p_add      = (p_q << 1) + (a_op[3'd7 - cnt_q] ? {2'b00, s_q} : 10'd0);
  assign p_sub      = p_add >= {2'b00, n_q} ? p_add - {2'b00, n_q} : p_add;
  assign p_mod      = p_sub >= {2'b00, n_q} ? p_sub - {2'b00, n_q} : p_sub;
  assign uo_out     = ui_in[7] ? {busy_q, done_q, err_q, 5'b00000} : res_q;
  assign uio_out    = 8'h00;
  assign uio_oe     = 8'h00;
  assign unused_w   = &{ena, ui_in[6:4]};
  // Sequencer: INIT, then eight MUL/SQR pairs walking E LSB first, then FIN.
  always_comb begin
    state_d = (state_q == IDLE || state_q == FIN) ? ((start_rise && !op_bad) ? INIT : IDLE)
            : state_q == INIT ? MUL
            : state_q == MUL  ? (last ? SQR : MUL)
            : state_q == SQR  ? (last ? (bit_q == 3'd7 ? FIN : MUL) : SQR)
            : IDLE;
  end
  // Operand registers, start detection and one shift-add step of the modular multiply per cycle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      m_q     <= 8'd0;
      e_q     <= 8'd0;
      n_q     <= 8'd0;
      res_q   <= 8'd0;
      r_q     <= 8'd0;
      s_q     <= 8'd0;
      p_q     <= 10'd0;
      cnt_q   <= 3'd0;
      bit_q   <= 3'd0;
      start_q <= 1'b0;
      arm_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= ui_in[3];
      arm_q   <= arm_q | ~ui_in[3];
      if (ui_in[2] && !busy_q && ui_in[1:0] == 2'd0) m_q <= uio_in;
      if (ui_in[2] && !busy_q && ui_in[1:0] == 2'd1) e_q <= uio_in;
      if (ui_in[2] && !busy_q && ui_in[1:0] == 2'd2) n_q <= uio_in;
      if (start_rise) begin
        busy_q <= ~op_bad;
        done_q <= op_bad;
        err_q  <= op_bad;
        if (op_bad) res_q <= 8'd0;
        r_q    <= 8'd1;
        s_q    <= m_q;
        p_q    <= 10'd0;
        cnt_q  <= 3'd0;
        bit_q  <= 3'd0;
      end
      if (state_q == MUL || state_q == SQR) begin
        cnt_q <= cnt_q + 3'd1;
        p_q   <= last ? 10'd0 : p_mod;
      end
      if (state_q == MUL && last && e_q[bit_q]) r_q <= p_mod[7:0];
      if (state_q == SQR && last) begin
        s_q   <= p_mod[7:0];
        bit_q <= bit_q + 3'd1;
      end
      if (state_q == SQR && last && bit_q == 3'd7) begin
        res_q  <= r_q;
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tt_um_calonso88_rsa_core.sv
// tb_tt_um_calonso88_rsa_core: cycle-level output model plus directed RSA vectors
module tb_tt_um_calonso88_rsa_core;
  logic clk, rst, st, we, view, ena;
  logic [1:0] addr;
  logic [7:0] uio, uo_out, uio_out, uio_oe, ui_in;
  int checks, fails, nb;
  logic chk_en;
  int mm, me, mn, mres, mpend, mcnt;
  logic mbusy, mdone, merr, mprev, marmed;
  assign ui_in = {view, 3'b000, st, we, addr};
  tt_um_calonso88_rsa_core dut (
    .ui_in(ui_in), .uo_out(uo_out), .uio_in(uio), .uio_out(uio_out),
    .uio_oe(uio_oe), .ena(ena), .clk(clk), .rst_n(rst)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic int modexp(input int m, input int e, input int n);
    int r = 1 % n;
    for (int i = 0; i < e; i++) r = (r * m) % n;
    return r;
  endfunction
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask
  // Spec-level model: countdown to completion, result from plain integer exponentiation.
  always @(posedge clk) begin
    if (rst) begin
      mm <= 0; me <= 0; mn <= 0; mres <= 0; mcnt <= 0; mpend <= 0;
      mbusy <= 1'b0; mdone <= 1'b0; merr <= 1'b0; mprev <= 1'b0; marmed <= 1'b0;
    end else begin
      mprev  <= st;
      marmed <= marmed | ~st;
      if (mbusy) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) begin
          mbusy <= 1'b0;
          mdone <= 1'b1;
          mres  <= mpend;
        end
      end else begin
        if (we && addr == 2'd0) mm <= int'(uio);
        if (we && addr == 2'd1) me <= int'(uio);
        if (we && addr == 2'd2) mn <= int'(uio);
        if (st && !mprev && marmed) begin
          if (mn < 2 || mm >= mn) begin
            merr <= 1'b1; mdone <= 1'b1; mres <= 0;
          end else begin
            mbusy <= 1'b1; mdone <= 1'b0; merr <= 1'b0; mcnt <= 129;
            mpend <= modexp(mm, me, mn);
          end
        end
      end
    end
  end
  // Every-cycle comparison against the model, well away from the rising edge.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      check("cyc_uo", {24'd0, uo_out}, view ? {24'd0, mbusy, mdone, merr, 5'b00000} : mres);
      check("cyc_uio_out", {24'd0, uio_out}, 32'd0);
      check("cyc_uio_oe", {24'd0, uio_oe}, 32'd0);
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk); addr = a; uio = d; we = 1'b1;
    @(negedge clk); we = 1'b0;
  endtask
  task automatic setops(input logic [7:0] m, input logic [7:0] e, input logic [7:0] n);
    wr(2'd0, m); wr(2'd1, e); wr(2'd2, n);
  endtask
  task automatic start_run();
    @(negedge clk); st = 1'b1;
    @(negedge clk); st = 1'b0;
  endtask
  task automatic look(input string nm, input logic v, input logic [7:0] exp);
    @(negedge clk); view = v; #1;
    check(nm, {24'd0, uo_out}, {24'd0, exp});
  endtask
  initial begin
    checks = 0; fails = 0; chk_en = 1'b0;
    rst = 1'b1; st = 1'b0; we = 1'b0; view = 1'b0; ena = 1'b1; addr = 2'd0; uio = 8'd0;
    tick(3);
    rst = 1'b0; chk_en = 1'b1;
    look("reset_result", 1'b0, 8'h00);
    look("reset_status", 1'b1, 8'h00);
    setops(8'd7, 8'd5, 8'd11);
    @(negedge clk); st = 1'b1; view = 1'b1; nb = 0;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk); st = 1'b0; #1;
      if (uo_out[7]) nb++;
      if (i == 60) check("run_status", {24'd0, uo_out}, 32'h80);
    end
    check("busy_cycles", nb, 129);
    look("done_status", 1'b1, 8'h40);
    look("res_7_5_11", 1'b0, 8'd10);
    setops(8'd88, 8'd7, 8'd187); start_run(); tick(135);
    look("res_88_7_187", 1'b0, 8'd11);
    setops(8'd11, 8'd23, 8'd187); start_run(); tick(135);
    look("res_11_23_187", 1'b0, 8'd88);
    setops(8'd5, 8'd0, 8'd13); start_run(); tick(135);
    look("res_e0", 1'b0, 8'd1);
    look("status_e0", 1'b1, 8'h40);
    setops(8'd20, 8'd5, 8'd1); start_run();
    look("err_n1_status", 1'b1, 8'h60);
    look("err_n1_result", 1'b0, 8'h00);
    setops(8'd20, 8'd5, 8'd13); start_run();
    look("err_m_ge_n_status", 1'b1, 8'h60);
    setops(8'd7, 8'd5, 8'd11); start_run(); tick(48);
    wr(2'd1, 8'd3); start_run(); tick(135);
    look("ignored_busy_result", 1'b0, 8'd10);
    look("ignored_busy_status", 1'b1, 8'h40);
    start_run(); tick(58);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    look("abort_status", 1'b1, 8'h00);
    look("abort_result", 1'b0, 8'h00);
    @(negedge clk); st = 1'b1; rst = 1'b1;
    tick(2);
    @(negedge clk); rst = 1'b0;
    tick(5);
    look("held_start_status", 1'b1, 8'h00);
    @(negedge clk); st = 1'b0;
    setops(8'd3, 8'd4, 8'd7); start_run(); tick(135);
    look("res_3_4_7", 1'b0, 8'd4);
    start_run(); tick(135);
    look("repeat_res_3_4_7", 1'b0, 8'd4);
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
